// File: rtl/sd_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_sequencer_if
//  Description : Request/status, SD CMD pad and CRC_7 engine signals of the
//                SD command sequencer, bundled with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_cmd_sequencer_if;
    // Request side (boot FSM)
    logic        cmd_start_i;
    logic [5:0]  cmd_index_i;
    logic [31:0] cmd_arg_i;
    logic        resp_en_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [47:0] resp_o;
    // SD pad side
    logic        bit_tick_i;
    logic        sd_cmd_i;
    logic        sd_cmd_o;
    logic        sd_cmd_oe_o;
    // CRC_7 engine side
    logic        crc_7_enable;
    logic [39:0] data_crc;
    logic [6:0]  crc_i;
    logic        flag_crc_done_i;

    // Environment view: drives requests, pad input and engine results
    modport master (
        output cmd_start_i, cmd_index_i, cmd_arg_i, resp_en_i,
        output bit_tick_i, sd_cmd_i, crc_i, flag_crc_done_i,
        input  busy_o, done_o, timeout_o, resp_o,
        input  sd_cmd_o, sd_cmd_oe_o, crc_7_enable, data_crc
    );

    // Sequencer view
    modport slave (
        input  cmd_start_i, cmd_index_i, cmd_arg_i, resp_en_i,
        input  bit_tick_i, sd_cmd_i, crc_i, flag_crc_done_i,
        output busy_o, done_o, timeout_o, resp_o,
        output sd_cmd_o, sd_cmd_oe_o, crc_7_enable, data_crc
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_sequencer
//  Description : Builds one 48-bit SD command frame per request, sequences the
//                external CRC_7 engine, drives the frame MSB first on the CMD
//                line and optionally captures a 48-bit response.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_sequencer #(
    parameter int RESP_TIMEOUT = 64,
    parameter int CRC_TIMEOUT  = 63
) (
    input  logic              control_clk_i,
    input  logic              control_rst_i,
    sd_cmd_sequencer_if.slave bus
);
    localparam int                  c_CRC_W     = $clog2(CRC_TIMEOUT + 1);
    localparam int                  c_RESP_W    = $clog2(RESP_TIMEOUT + 1);
    localparam logic [c_CRC_W-1:0]  c_CRC_LAST  = c_CRC_W'(CRC_TIMEOUT - 1);
    localparam logic [c_RESP_W-1:0] c_RESP_LAST = c_RESP_W'(RESP_TIMEOUT - 1);
    localparam logic [5:0]          c_LAST_BIT  = 6'd47;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_CRC       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RECV      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [39:0]           r_data_crc,   w_data_crc_nxt;
    logic                  r_resp_en,    w_resp_en_nxt;
    logic                  r_timeout,    w_timeout_nxt;
    logic [47:0]           r_shift,      w_shift_nxt;
    logic [5:0]            r_bit_cnt,    w_bit_cnt_nxt;
    logic [c_CRC_W-1:0]    r_crc_cnt,    w_crc_cnt_nxt;
    logic [c_RESP_W-1:0]   r_wait_cnt,   w_wait_cnt_nxt;
    logic [47:0]           r_resp_shift, w_resp_shift_nxt;
    logic [47:0]           r_resp,       w_resp_nxt;

    // State and datapath registers; reset aborts any transfer and frees the line
    always_ff @(posedge control_clk_i) begin
        if (!control_rst_i) begin
            r_state      <= ST_IDLE;
            r_data_crc   <= '0;
            r_resp_en    <= 1'b0;
            r_timeout    <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_crc_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_resp_shift <= '0;
            r_resp       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_crc   <= w_data_crc_nxt;
            r_resp_en    <= w_resp_en_nxt;
            r_timeout    <= w_timeout_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_crc_cnt    <= w_crc_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_resp_shift <= w_resp_shift_nxt;
            r_resp       <= w_resp_nxt;
        end
    end

    // Next-state, datapath updates and line/engine controls for each phase
    always_comb begin
        w_state_nxt      = r_state;
        w_data_crc_nxt   = r_data_crc;
        w_resp_en_nxt    = r_resp_en;
        w_timeout_nxt    = r_timeout;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_crc_cnt_nxt    = r_crc_cnt;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_resp_shift_nxt = r_resp_shift;
        w_resp_nxt       = r_resp;
        bus.sd_cmd_o     = 1'b1;
        bus.sd_cmd_oe_o  = 1'b0;
        bus.crc_7_enable = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_start_i) begin
                    w_data_crc_nxt = {2'b01, bus.cmd_index_i, bus.cmd_arg_i};
                    w_resp_en_nxt  = bus.resp_en_i;
                    w_timeout_nxt  = 1'b0;
                    w_state_nxt    = ST_LOAD;
                end
            end
            // Enable held low for one clock so the engine loads data_crc
            ST_LOAD: begin
                w_crc_cnt_nxt = '0;
                w_state_nxt   = ST_CRC;
            end
            ST_CRC: begin
                bus.crc_7_enable = 1'b1;
                if (bus.flag_crc_done_i) begin
                    w_shift_nxt   = {r_data_crc, bus.crc_i, 1'b1};
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_SEND;
                end else if (r_crc_cnt == c_CRC_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_crc_cnt_nxt = r_crc_cnt + 1'b1;
                end
            end
            ST_SEND: begin
                bus.sd_cmd_oe_o = 1'b1;
                bus.sd_cmd_o    = r_shift[47];
                if (bus.bit_tick_i) begin
                    w_shift_nxt = {r_shift[46:0], 1'b0};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt  = '0;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = r_resp_en ? ST_WAIT_RESP : ST_DONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            // A low sample is the response start bit, which counts as bit one
            ST_WAIT_RESP: begin
                if (bus.bit_tick_i) begin
                    if (!bus.sd_cmd_i) begin
                        w_resp_shift_nxt = '0;
                        w_bit_cnt_nxt    = 6'd1;
                        w_state_nxt      = ST_RECV;
                    end else if (r_wait_cnt == c_RESP_LAST) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_DONE;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (bus.bit_tick_i) begin
                    w_resp_shift_nxt = {r_resp_shift[46:0], bus.sd_cmd_i};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_resp_nxt  = {r_resp_shift[46:0], bus.sd_cmd_i};
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.done_o    = (r_state == ST_DONE);
    assign bus.timeout_o = r_timeout;
    assign bus.resp_o    = r_resp;
    assign bus.data_crc  = r_data_crc;
endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_cmd_sequencer
//  Description : Randomised scoreboard bench for sd_cmd_sequencer with a CRC_7
//                engine model and an SD card response model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_sequencer;
    localparam int c_RESP_TIMEOUT = 64;
    localparam int c_CRC_TIMEOUT  = 63;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(
        .RESP_TIMEOUT (c_RESP_TIMEOUT),
        .CRC_TIMEOUT  (c_CRC_TIMEOUT)
    ) dut (
        .control_clk_i (clk),
        .control_rst_i (rst_n),
        .bus           (bus.slave)
    );

    typedef struct {
        logic        sent;
        logic [47:0] frame;
        logic        tmo;
        logic [47:0] resp;
        logic        resp_en;
        logic        crc_stuck;
        logic        silent;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Environment configuration written by the driver
    int          tick_div     = 4;
    logic        card_respond = 1'b0;
    int          card_gap     = 2;
    logic [47:0] card_resp    = '0;
    logic        crc_stuck    = 1'b0;
    int          crc_lat      = 3;
    logic [47:0] resp_hold    = '0;
    logic        end_req      = 1'b0;
    int          mon_bits     = 0;

    // Environment state
    int   tcnt   = 0;
    int   ecnt   = 0;
    int   cstate = 0;
    int   gcnt   = 0;
    int   cbi    = 0;
    logic last_tick;

    // Monitor state
    logic        prev_oe   = 1'b0;
    logic        prev_line = 1'b1;
    logic [47:0] mframe    = '0;
    int          mbits     = 0;
    int          wticks    = 0;
    int          crcc      = 0;
    logic        chk_after = 1'b0;
    exp_t        me;

    // CRC7, generator x^7 + x^3 + 1, over the 40-bit command prefix
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Tick strobe, CRC_7 engine and SD card, all updated on the falling edge
    initial begin
        bus.bit_tick_i      = 1'b0;
        bus.sd_cmd_i        = 1'b1;
        bus.flag_crc_done_i = 1'b0;
        bus.crc_i           = '0;
        forever begin
            @(negedge clk);
            last_tick      = bus.bit_tick_i;
            bus.bit_tick_i = (tcnt == 0);
            tcnt           = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;

            if (!rst_n || !bus.crc_7_enable) begin
                ecnt                = 0;
                bus.flag_crc_done_i = 1'b0;
            end else begin
                ecnt++;
                if (!crc_stuck && ecnt >= crc_lat) begin
                    bus.flag_crc_done_i = 1'b1;
                    bus.crc_i           = crc7(bus.data_crc);
                end
            end

            if (!rst_n) begin
                cstate       = 0;
                bus.sd_cmd_i = 1'b1;
            end else begin
                case (cstate)
                    0: begin
                        bus.sd_cmd_i = 1'b1;
                        if (bus.sd_cmd_oe_o && card_respond) cstate = 1;
                    end
                    1: if (!bus.sd_cmd_oe_o) begin
                        if (!bus.busy_o) cstate = 0;
                        else begin
                            gcnt   = 0;
                            cstate = 2;
                            if (card_gap == 0) begin
                                cbi          = 47;
                                bus.sd_cmd_i = card_resp[47];
                                cstate       = 3;
                            end
                        end
                    end
                    2: if (last_tick) begin
                        gcnt++;
                        if (gcnt >= card_gap) begin
                            cbi          = 47;
                            bus.sd_cmd_i = card_resp[47];
                            cstate       = 3;
                        end
                    end
                    3: if (last_tick) begin
                        if (cbi == 0) begin
                            bus.sd_cmd_i = 1'b1;
                            cstate       = 0;
                        end else begin
                            cbi--;
                            bus.sd_cmd_i = card_resp[cbi];
                        end
                    end
                    default: cstate = 0;
                endcase
            end
        end
    end

    // Monitor: rebuilds the frame from the line and scores each completion
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (end_req) begin
                check("sb_drain", 48'(sb.size()), 48'd0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
            if (chk_after) begin
                chk_after = 1'b0;
                check("idle_after_done", {46'd0, bus.done_o, bus.busy_o}, 48'd0);
            end
            if (!rst_n) begin
                check("reset_ctrl", {42'd0, bus.sd_cmd_o, bus.sd_cmd_oe_o, bus.busy_o,
                                     bus.done_o, bus.timeout_o, bus.crc_7_enable}, 48'h20);
                check("reset_resp", bus.resp_o, 48'd0);
                check("reset_data_crc", {8'd0, bus.data_crc}, 48'd0);
                sb.delete();
                mbits  = 0;
                wticks = 0;
                crcc   = 0;
                mframe = '0;
            end else begin
                if (bus.bit_tick_i && prev_oe) begin
                    mframe = {mframe[46:0], prev_line};
                    mbits++;
                end else if (bus.bit_tick_i && mbits >= 48) begin
                    wticks++;
                end
                if (bus.crc_7_enable) crcc++;
                if (bus.done_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 48'd1, 48'd0);
                    end else begin
                        me = sb.pop_front();
                        if (me.sent) begin
                            check("frame_bits", 48'(mbits), 48'd48);
                            check("frame", mframe, me.frame);
                        end else begin
                            check("no_frame_bits", 48'(mbits), 48'd0);
                        end
                        check("timeout", {47'd0, bus.timeout_o}, {47'd0, me.tmo});
                        check("resp", bus.resp_o, me.resp);
                        if (me.crc_stuck) check("crc_clocks", 48'(crcc), 48'(c_CRC_TIMEOUT));
                        if (me.silent) check("wait_ticks", 48'(wticks), 48'(c_RESP_TIMEOUT));
                        if (me.sent && !me.resp_en) check("done_latency", 48'(wticks), 48'd0);
                    end
                    mbits     = 0;
                    wticks    = 0;
                    crcc      = 0;
                    mframe    = '0;
                    chk_after = 1'b1;
                end
            end
            mon_bits  = mbits;
            prev_oe   = bus.sd_cmd_oe_o;
            prev_line = bus.sd_cmd_o;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                           input int div, input logic silent, input logic stuck,
                           input int gap, input logic [47:0] rsp, input int lat,
                           input int abort_bit, input logic pulses,
                           input logic use_fixed, input logic [47:0] fixed_frame);
        exp_t e;
        int   n;
        n = 0;
        while (bus.busy_o) begin
            step();
            n++;
            if (n > 5000) begin
                $display("FAIL idle_wait: busy_o stuck at 1, want 0");
                $fatal(1);
            end
        end
        tick_div     = div;
        card_gap     = gap;
        card_resp    = rsp;
        card_respond = ren && !silent && !stuck;
        crc_stuck    = stuck;
        crc_lat      = lat;
        e.sent       = !stuck;
        e.frame      = use_fixed ? fixed_frame
                                 : {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
        e.tmo        = stuck || (ren && silent);
        e.resp       = (!stuck && ren && !silent) ? rsp : resp_hold;
        e.resp_en    = ren;
        e.crc_stuck  = stuck;
        e.silent     = ren && silent && !stuck;
        resp_hold    = e.resp;
        bus.cmd_index_i = idx;
        bus.cmd_arg_i   = arg;
        bus.resp_en_i   = ren;
        bus.cmd_start_i = 1'b1;
        sb.push_back(e);
        step();
        bus.cmd_start_i = 1'b0;
        n = 0;
        forever begin
            if (abort_bit >= 0 && mon_bits >= abort_bit) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n     = 1'b1;
                resp_hold = '0;
                break;
            end
            if (!bus.busy_o) break;
            if (pulses && $urandom_range(0, 5) == 0) begin
                bus.cmd_start_i = 1'b1;
                bus.cmd_index_i = 6'($urandom);
                bus.cmd_arg_i   = $urandom;
                bus.resp_en_i   = 1'($urandom);
            end else begin
                bus.cmd_start_i = 1'b0;
            end
            step();
            n++;
            if (n > 5000) begin
                $display("FAIL done_wait: no completion within 5000 clocks");
                $fatal(1);
            end
        end
        bus.cmd_start_i = 1'b0;
    endtask

    // Driver: directed scenarios followed by randomised commands
    initial begin
        logic [47:0] r;
        logic        ren;
        bus.cmd_start_i = 1'b0;
        bus.cmd_index_i = '0;
        bus.cmd_arg_i   = '0;
        bus.resp_en_i   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        run_cmd(6'd0, 32'h0, 1'b0, 4, 1'b0, 1'b0, 0, 48'h0, 3, -1, 1'b0, 1'b1, 48'h400000000095);
        run_cmd(6'd8, 32'h1AA, 1'b1, 4, 1'b0, 1'b0, 2, 48'h08000001AA13, 5, -1, 1'b0,
                1'b1, 48'h48000001AA87);
        run_cmd(6'd8, 32'h1AA, 1'b1, 2, 1'b1, 1'b0, 0, 48'h0, 2, -1, 1'b0, 1'b1, 48'h48000001AA87);
        run_cmd(6'd8, 32'h1AA, 1'b1, 3, 1'b0, 1'b1, 0, 48'h0, 2, -1, 1'b0, 1'b0, 48'h0);
        run_cmd(6'd17, 32'h0000_0200, 1'b0, 3, 1'b0, 1'b0, 0, 48'h0, 4, -1, 1'b1, 1'b0, 48'h0);
        run_cmd(6'd0, 32'h0, 1'b0, 3, 1'b0, 1'b0, 0, 48'h0, 2, 20, 1'b0, 1'b0, 48'h0);
        run_cmd(6'd0, 32'h0, 1'b0, 4, 1'b0, 1'b0, 0, 48'h0, 3, -1, 1'b0, 1'b1, 48'h400000000095);

        for (int t = 0; t < 24; t++) begin
            r   = {1'b0, 15'($urandom), $urandom};
            ren = 1'($urandom);
            run_cmd(6'($urandom), $urandom, ren, $urandom_range(1, 4),
                    ren && ($urandom_range(0, 7) == 0), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 12), r, $urandom_range(1, 20), -1,
                    1'($urandom), 1'b0, 48'h0);
        end

        while (bus.busy_o) step();
        repeat (5) step();
        end_req = 1'b1;
    end
endmodule
`default_nettype wire
